// File: rtl/apb_evt_master_pkg.sv
// Shared types and constants for the APB event master: FSM encoding and write-data tag.
package apb_evt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam logic [7:0] DATA_TAG = 8'hEA;

  // Index width that stays legal for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_evt_master_if.sv
// APB requester-side bus bundle for apb_evt_master; signal names keep the block's port naming.
interface apb_evt_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [ADDR_W-1:0] paddr_o;
  logic [DATA_W-1:0] pwdata_o;
  logic              pready_i;
  logic              pslverr_i;

  modport master (
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    input  pready_i, pslverr_i
  );

  modport slave (
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    output pready_i, pslverr_i
  );
endinterface

// File: rtl/apb_evt_arb.sv
// Channel arbiter for apb_evt_master: fixed lowest-index priority by default,
// round-robin starting after the last winner when APB_EVT_MASTER_RR_EN is defined.
module apb_evt_arb
  import apb_evt_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EVT-1:0] req_i,
  input  logic               adv_i,
  output logic [NUM_EVT-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  assign any_o = |req_i;
  assign gnt_o = any_o ? (NUM_EVT'(1) << idx_o) : '0;

`ifdef APB_EVT_MASTER_RR_EN
  logic [IDX_W-1:0] ptr_q;
  int               best_d;
  int               dist;

  // Pointer starts at the top channel so channel 0 is first after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= IDX_W'(NUM_EVT - 1);
    end else if (adv_i && any_o) begin
      ptr_q <= idx_o;
    end
  end

  always_comb begin
    idx_o  = '0;
    best_d = NUM_EVT;
    dist   = 0;
    for (int c = 0; c < NUM_EVT; c++) begin
      dist = (c + NUM_EVT - 1 - int'(ptr_q)) % NUM_EVT;
      if (req_i[c] && (dist < best_d)) begin
        best_d = dist;
        idx_o  = IDX_W'(c);
      end
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst, adv_i};

  always_comb begin
    idx_o = '0;
    for (int c = NUM_EVT - 1; c >= 0; c--) begin
      if (req_i[c]) idx_o = IDX_W'(c);
    end
  end
`endif

endmodule

// File: rtl/apb_evt_master.sv
// Turns per-channel event pulses into APB write transfers with sticky overflow/error flags.
// Arbitration mode is selected by APB_EVT_MASTER_RR_EN (undefined: fixed priority).
module apb_evt_master
  import apb_evt_pkg::*;
#(
  parameter int              NUM_EVT     = 4,
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h1000_1000),
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(32'h1000_1000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_EVT-1:0]  event_i,
  apb_evt_master_if.master    apb,
  input  logic                flag_clr_i,
  output logic [NUM_EVT-1:0]  ovf_o,
  output logic [NUM_EVT-1:0]  err_o,
  output logic                busy_o
);

  localparam int IDX_W = idx_width(NUM_EVT);

  apb_state_e         state_q, state_d;
  logic [NUM_EVT-1:0] pend_q, pend_d;
  logic [NUM_EVT-1:0] cur_oh_q, cur_oh_d;
  logic [NUM_EVT-1:0] ovf_q, ovf_d;
  logic [NUM_EVT-1:0] err_q, err_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        seq_q [NUM_EVT];
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]  paddr_q, paddr_d;
  logic [DATA_W-1:0]  pwdata_q, pwdata_d;

  logic               complete;
  logic               load;
  logic [NUM_EVT-1:0] comp_oh;
  logic [NUM_EVT-1:0] arb_req;
  logic [NUM_EVT-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  function automatic logic [ADDR_W-1:0] chan_addr(input logic [IDX_W-1:0] i);
    return BASE_ADDR + ADDR_STRIDE * ADDR_W'(i);
  endfunction

  assign complete = (state_q == ST_ACCESS) && apb.pready_i;
  assign comp_oh  = complete ? cur_oh_q : '0;
  // The retiring channel sits out the back-to-back decision even if re-requested.
  assign arb_req  = pend_q & ~comp_oh;

  apb_evt_arb #(
    .NUM_EVT (NUM_EVT),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (arb_req),
    .adv_i (load),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    pend_d = (pend_q & ~comp_oh) | event_i;
    ovf_d  = (flag_clr_i ? '0 : ovf_q) | (event_i & pend_q & ~comp_oh);
    err_d  = (flag_clr_i ? '0 : err_q) | ((complete && apb.pslverr_i) ? cur_oh_q : '0);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cur_oh_d  = cur_oh_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) load = 1'b1;
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (apb.pready_i) begin
          if (arb_any) begin
            load = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            pwrite_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = 1'b0;
      end
    endcase
    if (load) begin
      state_d   = ST_SETUP;
      idx_d     = arb_idx;
      cur_oh_d  = arb_gnt;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = 1'b1;
      paddr_d   = chan_addr(arb_idx);
      pwdata_d  = DATA_W'({DATA_TAG, 8'(arb_idx), seq_q[arb_idx]});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      cur_oh_q  <= '0;
      ovf_q     <= '0;
      err_q     <= '0;
      idx_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      for (int k = 0; k < NUM_EVT; k++) seq_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      cur_oh_q  <= cur_oh_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      for (int k = 0; k < NUM_EVT; k++) begin
        if (comp_oh[k]) seq_q[k] <= seq_q[k] + 16'd1;
      end
    end
  end

  assign apb.psel_o    = psel_q;
  assign apb.penable_o = penable_q;
  assign apb.pwrite_o  = pwrite_q;
  assign apb.paddr_o   = paddr_q;
  assign apb.pwdata_o  = pwdata_q;
  assign ovf_o         = ovf_q;
  assign err_o         = err_q;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: doc/apb_evt_master.md
APB_EVT_MASTER -- requirements
Module: apb_evt_master

Interface
REQ-001 Parameter NUM_EVT, default 4, number of event channels (1..16).
REQ-002 Parameter ADDR_W, default 32, APB address width.
REQ-003 Parameter DATA_W, default 32, APB write data width (>=32).
REQ-004 Parameter BASE_ADDR, default 32'h1000_1000, address of channel 0.
REQ-005 Parameter ADDR_STRIDE, default 32'h1000_1000, address increment per channel index.
REQ-006 Port clk  input  1  clock; all flops rising-edge.
REQ-007 Port rst  input  1  reset; synchronous, active-low.
REQ-008 Port event_i  input  NUM_EVT  per-channel event request, sampled every cycle.
REQ-009 Port psel_o, penable_o, pwrite_o  output  1 each  APB control.
REQ-010 Port paddr_o  output  ADDR_W  APB address.
REQ-011 Port pwdata_o  output  DATA_W  APB write data.
REQ-012 Port pready_i, pslverr_i  input  1 each  APB slave response.
REQ-013 Port ovf_o, err_o  output  NUM_EVT each  sticky per-channel overflow / slave-error flags.
REQ-014 Port flag_clr_i  input  1  clears ovf_o and err_o.
REQ-015 Port busy_o  output  1  high whenever FSM is not IDLE.

Function
REQ-016 Each cycle event_i[k]=1 SHALL set pending[k]; pending[k] clears only when channel k's transfer completes.
REQ-017 Event on channel k while pending[k] already set (and not completing that cycle) SHALL set ovf_o[k]; occurrence is merged.
REQ-018 Event on channel k in its completion cycle SHALL leave pending[k]=1, no overflow.
REQ-019 FSM states IDLE, SETUP, ACCESS; all APB outputs registered.
REQ-020 IDLE -> SETUP when any pending bit set; arbitration winner index latched for the whole transfer.
REQ-021 SETUP: psel_o=1, penable_o=0, pwrite_o=1; always -> ACCESS next cycle.
REQ-022 ACCESS: psel_o=1, penable_o=1; paddr_o, pwdata_o, pwrite_o held stable while pready_i=0 (unbounded wait states).
REQ-023 ACCESS with pready_i=1: transfer completes; -> SETUP if another pending bit set (back-to-back, psel_o stays 1), else -> IDLE with psel_o=0, penable_o=0.
REQ-024 Arbitration: fixed priority, lowest index wins.
REQ-025 paddr_o = BASE_ADDR + idx*ADDR_STRIDE, truncated to ADDR_W.
REQ-026 pwdata_o = {zeros, 8'hEA, 8-bit idx, 16-bit seq[idx]}; seq[idx] per channel, increments on each completion of idx, wraps 16'hFFFF -> 0.
REQ-027 pslverr_i=1 at completion SHALL set err_o[idx]; transfer is still retired (no retry).
REQ-028 flag_clr_i=1 clears ovf_o/err_o next cycle; a same-cycle set wins over clear.
REQ-029 Latency: event in cycle N from IDLE -> psel_o=1 at N+2, penable_o=1 at N+3.

Reset
REQ-030 rst=0 at clk edge SHALL force IDLE, psel_o=0, penable_o=0, pwrite_o=0, paddr_o=0, pwdata_o=0, pending=0, seq=0, ovf_o=0, err_o=0, busy_o=0.
REQ-031 Reset mid-transfer SHALL abort immediately; no completion, no seq increment.

Configuration
REQ-032 Macro APB_EVT_MASTER_RR_EN defined: round-robin arbitration, search starting at last winner+1 (wrapping); pointer resets to NUM_EVT-1 so channel 0 wins first.
REQ-033 Macro undefined: fixed priority per REQ-024; no pointer flops.

Structure
REQ-034 Package apb_evt_pkg holds FSM state enum (2 bits, IDLE=0, SETUP=1, ACCESS=2) and data tag constant 8'hEA.
REQ-035 Arbiter SHALL be sub-module apb_evt_arb (pending in, one-hot grant and index out, macro-selected mode).

Verification
REQ-036 Single event_i[1] pulse, pready_i=1 -> one write, paddr 32'h2000_2000, pwdata 32'hEA01_0000, psel at +2 cycles.
REQ-037 event_i=4'b1110 one cycle -> three back-to-back writes, order idx 1,2,3 (fixed) with psel_o never dropping.
REQ-038 pready_i low 5 cycles in ACCESS -> address/data/penable stable all 5 cycles; event_i[0] repeated twice meanwhile -> ovf_o[0]=1.
REQ-039 pslverr_i=1 on idx 2 completion -> err_o[2]=1, seq[2] advances; flag_clr_i pulse -> err_o=0.
REQ-040 rst=0 during ACCESS -> all outputs zero next edge; with RR_EN, events 4'b1111 held -> grants 0,1,2,3,0.
